multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. It is the producer of the 2-bit ALU_op consumed by ALU_Control.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select.
- Waits on a memory-ready handshake.
- Traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 15: max consecutive mem_ready=0 cycles tolerated in a memory-wait state; 0 disables the timeout; legal range 0..255.
- TRAP_ON_ILLEGAL, 1: 1 = an illegal opcode enters TRAP; 0 = it is treated as a NOP (DECODE -> FETCH).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction completes
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
- ALU_op  out  2  to ALU_Control: 00 add, 01 sub, 10 funct-decoded
- alu_funct_sel  out  1  1 = ALU_Control inst input takes opcode instead of funct (andi/ori)
- imm_zero_ext  out  1  1 = zero-extend immediate
- trap  out  1  FSM is in TRAP
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout
- state  out  4  current state code (debug)

Behaviour:
- Reset (async, reset_n low): state=IDLE, wait_cnt=0, trap_cause=00. All outputs are 0 while in IDLE.
- Outputs are decoded from state only, except that FETCH gates pc_write/ir_write with mem_ready. Any output not listed for a state is 0.
- IDLE(0): -> FETCH unconditionally.
- FETCH(1):
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALU_op=00.
  - pc_write = ir_write = mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE(2):
  - Drives alu_src_a=0, alu_src_b=11, ALU_op=00.
  - Next state by opcode: 000000 -> EXECUTE; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; 001000/001100/001101 -> IMM_EXEC.
  - Any other opcode -> TRAP with cause 01 if TRAP_ON_ILLEGAL=1, else -> FETCH.
- MEM_ADDR(3): alu_src_a=1, alu_src_b=10, ALU_op=00. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ(4): mem_read=1, i_or_d=1. mem_ready -> MEM_WB; otherwise stay.
- MEM_WB(5): reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
- MEM_WRITE(6): mem_write=1, i_or_d=1. mem_ready -> FETCH; otherwise stay.
- EXECUTE(7): alu_src_a=1, alu_src_b=00, ALU_op=10, alu_funct_sel=0. -> R_COMPLETE.
- R_COMPLETE(8): reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
- BRANCH(9): alu_src_a=1, alu_src_b=00, ALU_op=01, pc_write_cond=1, pc_source=01. -> FETCH.
- JUMP(10): pc_write=1, pc_source=10. -> FETCH.
- IMM_EXEC(11):
  - Drives alu_src_a=1, alu_src_b=10.
  - addi: ALU_op=00, imm_zero_ext=0.
  - andi/ori: ALU_op=10, alu_funct_sel=1, imm_zero_ext=1.
  - -> IMM_COMPLETE.
- IMM_COMPLETE(12): reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- TRAP(15):
  - trap=1; trap_cause holds its value; all other outputs 0.
  - Exit is by reset only.
- Timeout counter wait_cnt (8 bits):
  - Clears on entry to any state and in any cycle where mem_ready=1.
  - Increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - If MEM_TIMEOUT!=0, the cycle in which wait_cnt==MEM_TIMEOUT and mem_ready=0 transitions to TRAP with cause 10. Memory strobes drop on the next cycle.
  - mem_ready=1 in that same cycle wins: normal transition, no trap.
- Latency with zero wait states: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3 cycles (FETCH through last state).
- mem_ready is ignored in non-memory states.
- Reset asserted mid-instruction aborts it immediately; no partial write is issued after reset_n falls.

Test Plan:
- Reset then release, mem_ready=1, opcode=000000 -> state sequence 0,1,2,7,8,1. In state 8, reg_write=1 and reg_dst=1. In state 7, ALU_op=10.
- lw (100011) with mem_ready low 3 cycles in MEM_READ -> state stays 4 for 3 cycles, then 5 with mem_to_reg=1, reg_write=1. trap=0.
- andi (001100) -> in state 11: ALU_op=10, alu_funct_sel=1, imm_zero_ext=1, alu_src_b=10. Then state 12 with reg_write=1, reg_dst=0.
- beq (000100) -> state 9 with pc_write_cond=1, pc_source=01, ALU_op=01. Next state 1. Total 3 cycles.
- opcode=111111, TRAP_ON_ILLEGAL=1 -> TRAP, trap=1, trap_cause=01, held for 20 cycles. reset_n pulse -> IDLE.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> TRAP entered on the 16th cycle in FETCH, trap_cause=10. Repeat with mem_ready=1 on that cycle -> DECODE, no trap.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, drives datapath enables and mux selects, traps on bad opcode or memory stall.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALU_op,
  output logic       alu_funct_sel,
  output logic       imm_zero_ext,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE         = 4'd0;
  localparam logic [3:0] S_FETCH        = 4'd1;
  localparam logic [3:0] S_DECODE       = 4'd2;
  localparam logic [3:0] S_MEM_ADDR     = 4'd3;
  localparam logic [3:0] S_MEM_READ     = 4'd4;
  localparam logic [3:0] S_MEM_WB       = 4'd5;
  localparam logic [3:0] S_MEM_WRITE    = 4'd6;
  localparam logic [3:0] S_EXECUTE      = 4'd7;
  localparam logic [3:0] S_R_COMPLETE   = 4'd8;
  localparam logic [3:0] S_BRANCH       = 4'd9;
  localparam logic [3:0] S_JUMP         = 4'd10;
  localparam logic [3:0] S_IMM_EXEC     = 4'd11;
  localparam logic [3:0] S_IMM_COMPLETE = 4'd12;
  localparam logic [3:0] S_TRAP         = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);
  localparam bit         TMO_EN  = (MEM_TIMEOUT != 0);

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       alu_funct_sel;
    logic       imm_zero_ext;
  } ctl_t;

  logic [3:0] state_q, state_d;
  logic [7:0] wait_cnt, wait_cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       mem_wait, timeout;
  ctl_t       ctl;

  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  // A ready memory in the deadline cycle beats the timeout.
  assign timeout  = TMO_EN && mem_wait && !mem_ready && (wait_cnt == TMO);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:               state_d = S_EXECUTE;
          OP_LW, OP_SW:           state_d = S_MEM_ADDR;
          OP_BEQ:                 state_d = S_BRANCH;
          OP_J:                   state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMM_EXEC;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end else begin
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEM_ADDR:     state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:     if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:       state_d = S_FETCH;
      S_MEM_WRITE:    if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:      state_d = S_R_COMPLETE;
      S_R_COMPLETE:   state_d = S_FETCH;
      S_BRANCH:       state_d = S_FETCH;
      S_JUMP:         state_d = S_FETCH;
      S_IMM_EXEC:     state_d = S_IMM_COMPLETE;
      S_IMM_COMPLETE: state_d = S_FETCH;
      S_TRAP:         state_d = S_TRAP;
      default:        state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end
  end

  // Counts consecutive stalled cycles in one memory-wait state; saturates so a
  // disabled timeout never wraps back into a stale match.
  always_comb begin
    if ((state_d != state_q) || mem_ready || !mem_wait) wait_cnt_d = '0;
    else if (wait_cnt != 8'hFF)                         wait_cnt_d = wait_cnt + 8'd1;
    else                                                wait_cnt_d = wait_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_cnt_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.pc_write  = mem_ready;
        ctl.ir_write  = mem_ready;
      end
      S_DECODE:   ctl.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
      end
      S_R_COMPLETE: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = 2'b10;
      end
      S_IMM_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        // andi/ori route the opcode into ALU_Control and use a zero-extended immediate
        if (opcode != OP_ADDI) begin
          ctl.alu_op        = 2'b10;
          ctl.alu_funct_sel = 1'b1;
          ctl.imm_zero_ext  = 1'b1;
        end
      end
      S_IMM_COMPLETE: ctl.reg_write = 1'b1;
      default: ;
    endcase
  end

  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign pc_source     = ctl.pc_source;
  assign i_or_d        = ctl.i_or_d;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign ir_write      = ctl.ir_write;
  assign reg_dst       = ctl.reg_dst;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign reg_write     = ctl.reg_write;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign ALU_op        = ctl.alu_op;
  assign alu_funct_sel = ctl.alu_funct_sel;
  assign imm_zero_ext  = ctl.imm_zero_ext;
  assign trap          = (state_q == S_TRAP);
  assign trap_cause    = cause_q;
  assign state         = state_q;

endmodule
